// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, checks the width code and
// address range, drives a simple byte-addressed memory port and returns a
// single response (extended load data or an error flag).
//
// Ports:
//   clk, i_rst_n                    clock, asynchronous active-low reset
//   i_req_valid / o_req_ready       request handshake (ready only in IDLE)
//   i_is_store, i_funct3            operation and RISC-V width/sign code
//   i_addr, i_wdata                 byte address, LSB-aligned store data
//   o_rsp_valid / i_rsp_ready       response handshake
//   o_rsp_data, o_rsp_err           extended load data, error flag
//   o_mem_addr, o_mem_din           memory byte address, write data
//   o_mem_size                      01 byte, 10 half, 11 word
//   o_mem_wen, o_mem_ren            memory write / read enables
//   i_mem_dout                      memory read data, addressed byte in [7:0]
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_din,
    output logic [1:0]            o_mem_size,
    output logic                  o_mem_wen,
    output logic                  o_mem_ren,
    input  logic [31:0]           i_mem_dout
);

    localparam int unsigned SPAN_W   = 34;
    localparam logic [SPAN_W-1:0] MEM_LAST = (SPAN_W'(1) << ADDR_WIDTH) - SPAN_W'(1);
    localparam logic [2:0]        LAST_CNT = 3'(RD_LAT - 1);

    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [2:0]  funct3_q;
    logic        is_store_q;

    logic [1:0]        size_c;
    logic              legal_c;
    logic [SPAN_W-1:0] nbytes_c;
    logic [SPAN_W-1:0] last_byte_c;
    logic              err_c;

    // Decode the incoming request: access size, code legality, address span.
    always_comb begin
        size_c   = 2'b00;
        legal_c  = 1'b0;
        nbytes_c = SPAN_W'(1);
        case (i_funct3)
            3'b000: begin size_c = SIZE_BYTE; legal_c = 1'b1;        end
            3'b001: begin size_c = SIZE_HALF; legal_c = 1'b1;        end
            3'b010: begin size_c = SIZE_WORD; legal_c = 1'b1;        end
            3'b100: begin size_c = SIZE_BYTE; legal_c = !i_is_store; end
            3'b101: begin size_c = SIZE_HALF; legal_c = !i_is_store; end
            default: begin size_c = 2'b00;    legal_c = 1'b0;        end
        endcase
        case (size_c)
            SIZE_HALF: nbytes_c = SPAN_W'(2);
            SIZE_WORD: nbytes_c = SPAN_W'(4);
            default:   nbytes_c = SPAN_W'(1);
        endcase
        // Widened so a 32-bit address near the top cannot wrap past the check.
        last_byte_c = SPAN_W'(i_addr) + nbytes_c - SPAN_W'(1);
        err_c       = !legal_c || (last_byte_c > MEM_LAST);
    end

    // Sign/zero extension of the returned memory word.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'd0, d[7:0]};
            3'b101:  r = {16'd0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign o_req_ready = (state == IDLE);

    // Request FSM with registered memory and response outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            lat_cnt     <= 3'd0;
            funct3_q    <= 3'd0;
            is_store_q  <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= 32'd0;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_din   <= 32'd0;
            o_mem_size  <= 2'b00;
            o_mem_wen   <= 1'b0;
            o_mem_ren   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        funct3_q   <= i_funct3;
                        is_store_q <= i_is_store;
                        if (err_c) begin
                            // Rejected: straight to a response, memory untouched.
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_data  <= 32'd0;
                            state       <= RESP;
                        end else begin
                            o_mem_addr <= i_addr[ADDR_WIDTH-1:0];
                            o_mem_size <= size_c;
                            if (i_is_store) begin
                                o_mem_din <= i_wdata;
                                o_mem_wen <= 1'b1;
                                state     <= WRITE;
                            end else begin
                                o_mem_ren <= 1'b1;
                                lat_cnt   <= 3'd0;
                                state     <= READ_WAIT;
                            end
                        end
                    end
                end
                WRITE: begin
                    o_mem_wen   <= 1'b0;
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= 1'b0;
                    o_rsp_data  <= 32'd0;
                    state       <= RESP;
                end
                READ_WAIT: begin
                    // Read data is valid in the RD_LAT-th cycle of ren.
                    if (lat_cnt == LAST_CNT) begin
                        o_mem_ren   <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b0;
                        o_rsp_data  <= is_store_q ? 32'd0 : extend_load(funct3_q, i_mem_dout);
                        lat_cnt     <= 3'd0;
                        state       <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_data  <= 32'd0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
